// File: rtl/product_result_fifo.sv
// Result FIFO for the multiplier datapath: captures pushed products into a small
// first-word-fall-through circular buffer and keeps a running sum of accepted words.
module product_result_fifo #(
  parameter int p_data_width = 8,
  parameter int p_depth      = 4,
  parameter int p_addr_width = 2,
  parameter int p_acc_width  = 20
) (
  input  logic                        i_w_clk,
  input  logic                        i_w_reset,
  input  logic [2*p_data_width-1:0]   i_w_data,
  input  logic                        i_w_push,
  input  logic                        i_w_pop,
  input  logic                        i_w_acc_clear,
  output logic [2*p_data_width-1:0]   o_w_data,
  output logic                        o_w_empty,
  output logic                        o_w_full,
  output logic [p_addr_width:0]       o_w_count,
  output logic [p_acc_width-1:0]      o_w_acc,
  output logic                        o_w_overflow,
  output logic                        o_w_underflow
);

  localparam int                    LP_WORD_W = 2 * p_data_width;
  localparam logic [p_addr_width:0] LP_DEPTH  = (p_addr_width + 1)'(p_depth);
  localparam logic [p_addr_width:0] LP_CNT1   = (p_addr_width + 1)'(1);
  localparam logic [p_addr_width-1:0] LP_PTR1 = p_addr_width'(1);

  function automatic logic [p_acc_width-1:0] f_zext(input logic [LP_WORD_W-1:0] d);
    f_zext = p_acc_width'(d);
  endfunction

  logic [LP_WORD_W-1:0]    r_mem [p_depth];
  logic [p_addr_width-1:0] r_wr_ptr;
  logic [p_addr_width-1:0] r_rd_ptr;
  logic [p_addr_width:0]   r_count;
  logic [p_acc_width-1:0]  r_acc;
  logic                    r_overflow;
  logic                    r_underflow;

  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign w_push_ok = i_w_push & (~w_full | i_w_pop);
  assign w_pop_ok  = i_w_pop & ~w_empty;

  always_ff @(posedge i_w_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_w_data;
    end
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + LP_CNT1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - LP_CNT1;
      end
      if (i_w_acc_clear) begin
        r_acc <= w_push_ok ? f_zext(i_w_data) : '0;
      end else if (w_push_ok) begin
        r_acc <= r_acc + f_zext(i_w_data);
      end
      if (i_w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      if (i_w_pop && !w_pop_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_w_data      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_w_empty     = w_empty;
  assign o_w_full      = w_full;
  assign o_w_count     = r_count;
  assign o_w_acc       = r_acc;
  assign o_w_overflow  = r_overflow;
  assign o_w_underflow = r_underflow;

endmodule
